// File: rtl/pc16_pkg.sv
// Shared constants and types for the pc16 program counter.
//   PC_WIDTH_DEF       default counter/address width
//   PC_STACK_DEPTH_DEF default return-stack depth
//   pc_state_e         control FSM states (RUN / FAULT)
package pc16_pkg;

  localparam int unsigned PC_WIDTH_DEF       = 16;
  localparam int unsigned PC_STACK_DEPTH_DEF = 4;

  typedef enum logic {
    PC_ST_RUN   = 1'b0,
    PC_ST_FAULT = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc16_if.sv
// Control/data bundle between the CPU datapath and the program counter.
//   master: drives in/load/inc/push/pop, observes out/stack flags/err
//   slave : the PC itself (pc16)
interface pc16_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic             inc;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] out;
  logic             stack_empty;
  logic             stack_full;
  logic             err;

  modport master (
    output in, load, inc, push, pop,
    input  out, stack_empty, stack_full, err
  );

  modport slave (
    input  in, load, inc, push, pop,
    output out, stack_empty, stack_full, err
  );
endinterface

// File: rtl/pc16_ret_stack.sv
// ret_stack: LIFO of return addresses.
//   clk, reset : clock, synchronous active-high reset (clears pointer only)
//   push/wdata : store wdata on top (ignored when full)
//   pop        : discard top (ignored when empty); pop beats push
//   rdata      : current top entry (valid when !empty)
//   full/empty : registered occupancy flags
module ret_stack #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(STACK_DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [PW-1:0]    sp_q, sp_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop && !empty_q;
    do_push = push && !pop && !full_q;
    sp_d    = sp_q;
    if (do_pop)       sp_d = sp_q - 1'b1;
    else if (do_push) sp_d = sp_q + 1'b1;
    empty_d = (sp_d == '0);
    full_d  = (sp_d == PW'(STACK_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Storage is never cleared; only the pointer defines what is live.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[sp_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[AW'(sp_q - 1'b1)];
  assign full  = full_q;
  assign empty = empty_q;
endmodule

// File: rtl/pc16.sv
// pc16: Hack-CPU program counter with optional return-address stack.
//   clk, reset : clock, synchronous active-high reset
//   bus        : pc16_if.slave (in, load, inc, push, pop -> out,
//                stack_empty, stack_full, err)
// Build option PC_CALL_STACK_EN: enables call/return stack, flags and
// sticky err. Without it push/pop are ignored and the flags are constant.
// Priority per edge: reset > pop > push > load > inc > hold.
module pc16
  import pc16_pkg::*;
#(
  parameter int unsigned WIDTH       = PC_WIDTH_DEF,
  parameter int unsigned STACK_DEPTH = PC_STACK_DEPTH_DEF
) (
  input logic   clk,
  input logic   reset,
  pc16_if.slave bus
);
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc = pc_q + WIDTH'(1);

`ifdef PC_CALL_STACK_EN
  logic             stk_full, stk_empty;
  logic [WIDTH-1:0] stk_top;
  logic             fault_ev;
  logic             err_o;
  pc_state_e        state_q, state_d;

  ret_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (bus.push),
    .pop   (bus.pop),
    .wdata (pc_inc),
    .rdata (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // A push that loses to a same-cycle pop never counts as an overflow.
  assign fault_ev = (bus.pop && stk_empty) ||
                    (bus.push && !bus.pop && stk_full);

  always_comb begin
    pc_d = pc_q;
    if (bus.pop)       pc_d = stk_empty ? pc_q : stk_top;
    else if (bus.push) pc_d = stk_full ? pc_q : bus.in;
    else if (bus.load) pc_d = bus.in;
    else if (bus.inc)  pc_d = pc_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= PC_ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PC_ST_RUN:   if (fault_ev) state_d = PC_ST_FAULT;
      PC_ST_FAULT: state_d = PC_ST_FAULT;
      default:     state_d = PC_ST_RUN;
    endcase
  end

  always_comb begin
    err_o = (state_q == PC_ST_FAULT);
  end

  assign bus.stack_empty = stk_empty;
  assign bus.stack_full  = stk_full;
  assign bus.err         = err_o;
`else
  logic unused_stack_req;
  assign unused_stack_req = bus.push ^ bus.pop;

  always_comb begin
    pc_d = pc_q;
    if (bus.load)     pc_d = bus.in;
    else if (bus.inc) pc_d = pc_inc;
  end

  assign bus.stack_empty = 1'b1;
  assign bus.stack_full  = 1'b0;
  assign bus.err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign bus.out = pc_q;
endmodule
